// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC redirect controller: FSM states, redirect priorities, flush set.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned PRIW = 2;

  localparam logic [PRIW-1:0] PRI_TRAP = 2'd0;
  localparam logic [PRIW-1:0] PRI_BR   = 2'd1;
  localparam logic [PRIW-1:0] PRI_JMP  = 2'd2;
  localparam logic [PRIW-1:0] PRI_NONE = 2'd3;

  typedef struct packed {
    logic if_f;
    logic id_f;
    logic ex_f;
  } flush_t;

  // Older stages hold wrong-path work only for the more senior redirect sources.
  function automatic flush_t flush_of(input logic [PRIW-1:0] pri);
    flush_t f;
    f.if_f = (pri != PRI_NONE);
    f.id_f = (pri == PRI_TRAP) || (pri == PRI_BR);
    f.ex_f = (pri == PRI_TRAP);
    return f;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_redir_arb.sv
// Fixed-priority redirect arbiter: trap > EX branch > ID jump.
module redir_arb
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH = 32
) (
  input  logic              trap_valid_i,
  input  logic [AWIDTH-1:0] trap_target_i,
  input  logic              br_valid_i,
  input  logic [AWIDTH-1:0] br_target_i,
  input  logic              jmp_valid_i,
  input  logic [AWIDTH-1:0] jmp_target_i,
  output logic              win_vld_o,
  output logic [PRIW-1:0]   win_pri_o,
  output logic [AWIDTH-1:0] win_tgt_o
);

  always_comb begin
    win_vld_o = 1'b1;
    win_pri_o = PRI_NONE;
    win_tgt_o = '0;
    if (trap_valid_i) begin
      win_pri_o = PRI_TRAP;
      win_tgt_o = trap_target_i;
    end else if (br_valid_i) begin
      win_pri_o = PRI_BR;
      win_tgt_o = br_target_i;
    end else if (jmp_valid_i) begin
      win_pri_o = PRI_JMP;
      win_tgt_o = jmp_target_i;
    end else begin
      win_vld_o = 1'b0;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// IF-stage PC sequencer: boot hold, redirect arbitration, stall buffering/replay, flushes.
// Optional build macro PC_ALIGN_CHK_EN turns misaligned branch/jump targets into a trap.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned BOOT_CYCLES = 2
`ifdef PC_ALIGN_CHK_EN
  , parameter logic [AWIDTH-1:0] TRAP_VEC = AWIDTH'(32'h4000_0100)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              trap_valid_in,
  input  logic [AWIDTH-1:0] trap_target_in,
  input  logic              br_valid_in,
  input  logic [AWIDTH-1:0] br_target_in,
  input  logic              jmp_valid_in,
  input  logic [AWIDTH-1:0] jmp_target_in,
  output logic              fetch_en_out,
  output logic              pc_sel_out,
  output logic [AWIDTH-1:0] pc_new_out,
  output logic              flush_if_out,
  output logic              flush_id_out,
  output logic              flush_ex_out,
  output logic              pending_out,
  output logic [15:0]       redir_cnt_out
);

  localparam int unsigned BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned CW  = 16;

  state_e            state_q, state_d;
  logic [BCW-1:0]    boot_cnt_q, boot_cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [AWIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [PRIW-1:0]   pend_pri_q, pend_pri_d;
  logic [CW-1:0]     cnt_q;
  logic              cnt_inc;
  flush_t            flush_c;

  logic              a_vld;
  logic [PRIW-1:0]   a_pri;
  logic [AWIDTH-1:0] a_tgt;
  logic [PRIW-1:0]   w_pri;
  logic [AWIDTH-1:0] w_tgt;

  redir_arb #(.AWIDTH(AWIDTH)) u_arb (
    .trap_valid_i  (trap_valid_in),
    .trap_target_i (trap_target_in),
    .br_valid_i    (br_valid_in),
    .br_target_i   (br_target_in),
    .jmp_valid_i   (jmp_valid_in),
    .jmp_target_i  (jmp_target_in),
    .win_vld_o     (a_vld),
    .win_pri_o     (a_pri),
    .win_tgt_o     (a_tgt)
  );

`ifdef PC_ALIGN_CHK_EN
  // A misaligned branch/jump target is promoted to a trap to the fixed vector.
  always_comb begin
    w_pri = a_pri;
    w_tgt = a_tgt;
    if (a_vld && (a_pri != PRI_TRAP) && (a_tgt[1:0] != 2'b00)) begin
      w_pri = PRI_TRAP;
      w_tgt = TRAP_VEC;
    end
  end
`else
  assign w_pri = a_pri;
  assign w_tgt = a_tgt;
`endif

  // Next-state and combinational control outputs (0-cycle redirect into IF).
  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pend_vld_d   = pend_vld_q;
    pend_tgt_d   = pend_tgt_q;
    pend_pri_d   = pend_pri_q;
    cnt_inc      = 1'b0;
    flush_c      = '0;
    fetch_en_out = 1'b0;
    pc_sel_out   = 1'b0;
    pc_new_out   = '0;
    case (state_q)
      BOOT: begin
        if (boot_cnt_q == BCW'(BOOT_CYCLES - 1)) state_d = RUN;
        else                                     boot_cnt_d = boot_cnt_q + BCW'(1);
      end
      RUN: begin
        fetch_en_out = !stall_in;
        if (a_vld) begin
          flush_c = flush_of(w_pri);
          if (!stall_in) begin
            pc_sel_out = 1'b1;
            pc_new_out = w_tgt;
            cnt_inc    = 1'b1;
          end else begin
            pend_vld_d = 1'b1;
            pend_tgt_d = w_tgt;
            pend_pri_d = w_pri;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (stall_in) begin
          if (a_vld && (w_pri <= pend_pri_q)) begin
            flush_c    = flush_of(w_pri);
            pend_tgt_d = w_tgt;
            pend_pri_d = w_pri;
          end
        end else begin
          fetch_en_out = 1'b1;
          pc_sel_out   = 1'b1;
          cnt_inc      = 1'b1;
          pend_vld_d   = 1'b0;
          pend_pri_d   = PRI_NONE;
          state_d      = RUN;
          if (a_vld && (w_pri < pend_pri_q)) begin
            pc_new_out = w_tgt;
            flush_c    = flush_of(w_pri);
          end else begin
            pc_new_out   = pend_tgt_q;
            flush_c.if_f = 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      pend_pri_q <= PRI_NONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      pend_pri_q <= pend_pri_d;
      if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + CW'(1);
    end
  end

  assign flush_if_out  = flush_c.if_f;
  assign flush_id_out  = flush_c.id_f;
  assign flush_ex_out  = flush_c.ex_f;
  assign pending_out   = pend_vld_q;
  assign redir_cnt_out = cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl with a simple IF PC register; directed steps then random traffic.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] TB_TRAP  = 32'h4000_0100;

  logic        clk, rst_n;
  logic        stall_in, trap_valid_in, br_valid_in, jmp_valid_in;
  logic [31:0] trap_target_in, br_target_in, jmp_target_in;
  logic        fetch_en_out, pc_sel_out;
  logic [31:0] pc_new_out;
  logic        flush_if_out, flush_id_out, flush_ex_out, pending_out;
  logic [15:0] redir_cnt_out;
  logic [31:0] if_pc;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: cycles left in boot, buffered redirect, counter, expected PC.
  int          m_boot_left;
  bit          m_pend;
  logic [31:0] m_ptgt;
  int          m_ppri;
  int          m_cnt;
  logic [31:0] m_pc;

  pc_redirect_ctrl #(.AWIDTH(32), .BOOT_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_in       (stall_in),
    .trap_valid_in  (trap_valid_in),
    .trap_target_in (trap_target_in),
    .br_valid_in    (br_valid_in),
    .br_target_in   (br_target_in),
    .jmp_valid_in   (jmp_valid_in),
    .jmp_target_in  (jmp_target_in),
    .fetch_en_out   (fetch_en_out),
    .pc_sel_out     (pc_sel_out),
    .pc_new_out     (pc_new_out),
    .flush_if_out   (flush_if_out),
    .flush_id_out   (flush_id_out),
    .flush_ex_out   (flush_ex_out),
    .pending_out    (pending_out),
    .redir_cnt_out  (redir_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          if_pc <= RESET_PC;
    else if (pc_sel_out) if_pc <= pc_new_out;
    else if (fetch_en_out) if_pc <= if_pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_boot_left = 2;
    m_pend      = 1'b0;
    m_ptgt      = '0;
    m_ppri      = 3;
    m_cnt       = 0;
    m_pc        = RESET_PC;
  endtask

  // Called just after a posedge; reset drops between edges with requests active.
  task automatic do_reset();
    #2;
    stall_in = 1'b0; trap_valid_in = 1'b1; trap_target_in = 32'h1234_5678;
    br_valid_in = 1'b1; br_target_in = 32'h2000_0000;
    jmp_valid_in = 1'b0; jmp_target_in = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_fetch_en", 32'(fetch_en_out), 32'd0);
    chk("rst_pc_sel",   32'(pc_sel_out),   32'd0);
    chk("rst_pc_new",   pc_new_out,        32'd0);
    chk("rst_flush",    32'({flush_if_out, flush_id_out, flush_ex_out}), 32'd0);
    chk("rst_pending",  32'(pending_out),  32'd0);
    chk("rst_cnt",      32'(redir_cnt_out), 32'd0);
    chk("rst_pc",       if_pc,             RESET_PC);
    trap_valid_in = 1'b0; br_valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, check outputs against the model, then advance the model.
  task automatic cyc(input logic s, input logic tv, input logic [31:0] tt,
                     input logic bv, input logic [31:0] bt,
                     input logic jv, input logic [31:0] jt);
    int          wp;
    logic [31:0] wt;
    bit          e_fe, e_sel, e_fi, e_fd, e_fx, e_po, inc, booting;
    logic [31:0] e_new;
    bit          n_pend;
    logic [31:0] n_ptgt;
    int          n_ppri;
    @(negedge clk);
    stall_in = s;
    trap_valid_in = tv; trap_target_in = tt;
    br_valid_in = bv;   br_target_in = bt;
    jmp_valid_in = jv;  jmp_target_in = jt;
    #1;
    chk("pc", if_pc, m_pc);
    wp = 3; wt = '0;
    if (tv)      begin wp = 0; wt = tt; end
    else if (bv) begin wp = 1; wt = bt; end
    else if (jv) begin wp = 2; wt = jt; end
`ifdef PC_ALIGN_CHK_EN
    if ((wp == 1 || wp == 2) && wt[1:0] != 2'b00) begin wp = 0; wt = TB_TRAP; end
`endif
    e_fe = 0; e_sel = 0; e_fi = 0; e_fd = 0; e_fx = 0; e_po = m_pend; inc = 0;
    e_new = '0;
    n_pend = m_pend; n_ptgt = m_ptgt; n_ppri = m_ppri;
    booting = (m_boot_left > 0);
    if (booting) begin
      e_po = 0;
    end else if (!m_pend) begin
      e_fe = !s;
      if (wp < 3) begin
        e_fi = 1; e_fd = (wp <= 1); e_fx = (wp == 0);
        if (!s) begin e_sel = 1; e_new = wt; inc = 1; end
        else begin n_pend = 1; n_ptgt = wt; n_ppri = wp; end
      end
    end else if (s) begin
      if (wp <= m_ppri) begin
        e_fi = 1; e_fd = (wp <= 1); e_fx = (wp == 0);
        n_ptgt = wt; n_ppri = wp;
      end
    end else begin
      e_fe = 1; e_sel = 1; inc = 1; n_pend = 0; n_ppri = 3;
      if (wp < m_ppri) begin
        e_new = wt; e_fi = 1; e_fd = (wp <= 1); e_fx = (wp == 0);
      end else begin
        e_new = m_ptgt; e_fi = 1;
      end
    end
    chk("fetch_en", 32'(fetch_en_out), 32'(e_fe));
    chk("pc_sel",   32'(pc_sel_out),   32'(e_sel));
    if (e_sel) chk("pc_new", pc_new_out, e_new);
    chk("flush_if", 32'(flush_if_out), 32'(e_fi));
    chk("flush_id", 32'(flush_id_out), 32'(e_fd));
    chk("flush_ex", 32'(flush_ex_out), 32'(e_fx));
    chk("pending",  32'(pending_out),  32'(e_po));
    chk("redir_cnt", 32'(redir_cnt_out), 32'(m_cnt));
    @(posedge clk);
    if (booting) m_boot_left--;
    m_pend = n_pend; m_ptgt = n_ptgt; m_ppri = n_ppri;
    if (inc && m_cnt < 16'hFFFF) m_cnt++;
    if (e_sel)     m_pc = e_new;
    else if (e_fe) m_pc = m_pc + 32'd4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [31:0] rt, rb, rj;
    rst_n = 1'b0;
    stall_in = 0; trap_valid_in = 0; br_valid_in = 0; jmp_valid_in = 0;
    trap_target_in = '0; br_target_in = '0; jmp_target_in = '0;
    model_reset();
    @(posedge clk);
    do_reset();

    // Boot hold then sequential fetch.
    idle(5);
    // Branch in RUN.
    cyc(1'b0, 1'b0, '0, 1'b1, 32'h2000_0000, 1'b0, '0);
    idle(2);
    // Three-way contention: trap wins, single count.
    cyc(1'b0, 1'b1, TB_TRAP, 1'b1, 32'h2000_0000, 1'b1, 32'h3000_0000);
    idle(2);
    // Stall capture, higher-priority overwrite, dropped lower request, replay.
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3000_0000);
    cyc(1'b1, 1'b0, '0, 1'b1, 32'h2000_0000, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3000_0040);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    idle(2);
    // Replay pre-empted by a same-cycle trap.
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'h3000_0000);
    cyc(1'b0, 1'b1, 32'h5000_0000, 1'b0, '0, 1'b0, '0);
    idle(1);
    // Misaligned branch target.
    cyc(1'b0, 1'b0, '0, 1'b1, 32'h2000_0002, 1'b0, '0);
    idle(2);
    // Async reset while HOLD: pending discarded, no replay after boot.
    cyc(1'b1, 1'b0, '0, 1'b1, 32'h2000_0000, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    do_reset();
    idle(6);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rt = $urandom; rb = $urandom; rj = $urandom;
      if ($urandom_range(5, 0) != 0) rb[1:0] = 2'b00;
      if ($urandom_range(5, 0) != 0) rj[1:0] = 2'b00;
      cyc(($urandom_range(2, 0) == 0), ($urandom_range(7, 0) == 0), rt,
          ($urandom_range(4, 0) == 0), rb, ($urandom_range(3, 0) == 0), rj);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
